uart_rx_os: RTL and testbench



---
 rtl/uart_rx_os_if.sv | 24 ++
 rtl/uart_rx_os.sv | 146 ++++++++++++++
 tb/tb_uart_rx_os.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_os_if.sv
// Receive-side bundle from the UART receiver to the command/IIC bridge.
// The receiver drives every signal; the bridge only observes.
interface uart_rx_os_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 rx_busy;

    modport master (
        output rx_data,
        output rx_valid,
        output frame_err,
        output rx_busy
    );

    modport slave (
        input rx_data,
        input rx_valid,
        input frame_err,
        input rx_busy
    );
endinterface

// File: rtl/uart_rx_os.sv
// Oversampled 8N1 UART receiver: 2-FF synchroniser, start-bit check,
// majority-of-3 mid-bit sampling, stop-bit check and break hold-off.
module uart_rx_os #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic         clk_50m,
    input  logic         rst_n,
    input  logic         os_tick,
    input  logic         rxd,
    uart_rx_os_if.master rx
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int M  = OVERSAMPLE / 2;

    localparam logic [TW-1:0] T_LO   = TW'(M - 1);
    localparam logic [TW-1:0] T_MID  = TW'(M);
    localparam logic [TW-1:0] T_HI   = TW'(M + 1);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [2:0]    B_LAST = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t               state, state_n;
    logic [1:0]           sync;
    logic [TW-1:0]        tick_cnt, tick_n;
    logic [2:0]           bit_cnt, bit_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic [DATA_BITS-1:0] data_q, data_n;
    logic [1:0]           smp, smp_n;
    logic                 valid_q, valid_n;
    logic                 err_q, err_n;

    logic          rxd_s;
    logic [TW-1:0] tick_inc;
    logic          decide;
    logic          maj;

    assign rxd_s    = sync[1];
    assign tick_inc = (tick_cnt == T_LAST) ? '0 : tick_cnt + 1'b1;
    assign decide   = os_tick && (tick_cnt == T_HI);
    // Third sample is the live synchronised level at the deciding tick
    assign maj = (smp[0] & smp[1]) | (smp[0] & rxd_s) | (smp[1] & rxd_s);

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            sync     <= 2'b11;
            state    <= ST_IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            smp      <= 2'b11;
            data_q   <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            sync     <= {sync[0], rxd};
            state    <= state_n;
            tick_cnt <= tick_n;
            bit_cnt  <= bit_n;
            shreg    <= shreg_n;
            smp      <= smp_n;
            data_q   <= data_n;
            valid_q  <= valid_n;
            err_q    <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        tick_n  = tick_cnt;
        bit_n   = bit_cnt;
        shreg_n = shreg;
        smp_n   = smp;
        data_n  = data_q;
        valid_n = 1'b0;
        err_n   = 1'b0;

        if (os_tick && (tick_cnt == T_LO)) smp_n[0] = rxd_s;
        if (os_tick && (tick_cnt == T_MID)) smp_n[1] = rxd_s;

        unique case (state)
            ST_IDLE: begin
                if (!rxd_s) begin
                    tick_n  = '0;
                    state_n = ST_START;
                end
            end
            ST_START: begin
                if (os_tick) begin
                    tick_n = tick_inc;
                    if (decide && maj) begin
                        tick_n  = '0;
                        state_n = ST_IDLE;
                    end else if (tick_cnt == T_LAST) begin
                        bit_n   = '0;
                        state_n = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (os_tick) begin
                    tick_n = tick_inc;
                    if (decide)
                        shreg_n = {maj, shreg[DATA_BITS-1:1]};
                    if (tick_cnt == T_LAST) begin
                        if (bit_cnt == B_LAST) state_n = ST_STOP;
                        else bit_n = bit_cnt + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (os_tick) begin
                    tick_n = tick_inc;
                    if (decide) begin
                        tick_n = '0;
                        bit_n  = '0;
                        if (maj) begin
                            data_n  = shreg;
                            valid_n = 1'b1;
                            state_n = ST_IDLE;
                        end else begin
                            err_n   = 1'b1;
                            state_n = ST_BREAK;
                        end
                    end
                end
            end
            ST_BREAK: begin
                if (rxd_s) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign rx.rx_data   = data_q;
    assign rx.rx_valid  = valid_q;
    assign rx.frame_err = err_q;
    assign rx.rx_busy   = (state != ST_IDLE);
endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: random and directed 8N1 frames checked against
// a frame-level expectation of what the receiver must deliver.
module tb_uart_rx_os;
    logic clk_50m = 1'b0;
    logic rst_n   = 1'b0;
    logic os_tick = 1'b0;
    logic rxd     = 1'b1;

    int os_div  = 27;
    int div_cnt = 0;

    int passed = 0;
    int total  = 0;

    logic [7:0] valid_log[$];
    int         err_total  = 0;
    int         both_total = 0;
    logic [7:0] last_good  = 8'h00;

    uart_rx_os_if #(.DATA_BITS(8)) rif ();

    uart_rx_os #(
        .DATA_BITS (8),
        .OVERSAMPLE(16)
    ) dut (
        .clk_50m(clk_50m),
        .rst_n  (rst_n),
        .os_tick(os_tick),
        .rxd    (rxd),
        .rx     (rif)
    );

    always #10 clk_50m = ~clk_50m;

    always @(negedge clk_50m) begin
        if (div_cnt >= os_div - 1) begin
            div_cnt = 0;
            os_tick = 1'b1;
        end else begin
            div_cnt = div_cnt + 1;
            os_tick = 1'b0;
        end
    end

    always @(negedge clk_50m) begin
        #1;
        if (rif.rx_valid) valid_log.push_back(rif.rx_data);
        if (rif.frame_err) err_total = err_total + 1;
        if (rif.rx_valid && rif.frame_err) both_total = both_total + 1;
    end

    task automatic hold(input int clks);
        repeat (clks) @(negedge clk_50m);
    endtask

    task automatic drive_bit(input logic v, input logic spike);
        rxd = v;
        if (spike) begin
            hold(8 * os_div);
            rxd = ~v;
            hold(os_div);
            rxd = v;
            hold(7 * os_div);
        end else begin
            hold(16 * os_div);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop,
                              input int spike_bit);
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i], spike_bit == i);
        drive_bit(stop, 1'b0);
    endtask

    task automatic idle_bits(input int n);
        rxd = 1'b1;
        hold(n * 16 * os_div);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        rxd   = 1'b1;
        hold(3);
        total++;
        if (rif.rx_data !== 8'h00) $display("FAIL reset_data: got %h want 00", rif.rx_data);
        else passed++;
        total++;
        if (rif.rx_valid !== 1'b0 || rif.frame_err !== 1'b0)
            $display("FAIL reset_strobes: got %b%b want 00", rif.rx_valid, rif.frame_err);
        else passed++;
        rst_n = 1'b1;
        hold(5);
        total++;
        if (rif.rx_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", rif.rx_busy);
        else passed++;
        last_good = 8'h00;
    endtask

    task automatic test_basic;
        logic [7:0] pat[3];
        int base, errs;
        pat[0] = 8'h55; pat[1] = 8'h01; pat[2] = 8'h80;
        for (int i = 0; i < 3; i++) begin
            base = valid_log.size();
            errs = err_total;
            send_frame(pat[i], 1'b1, -1);
            idle_bits(1);
            total++;
            if (valid_log.size() != base + 1)
                $display("FAIL basic_count: got %0d want 1", valid_log.size() - base);
            else passed++;
            total++;
            if (valid_log[base] !== pat[i] || rif.rx_data !== pat[i])
                $display("FAIL basic_data: got %h want %h", rif.rx_data, pat[i]);
            else passed++;
            total++;
            if (err_total != errs || rif.rx_busy !== 1'b0)
                $display("FAIL basic_idle: errs %0d busy %b want 0 0",
                         err_total - errs, rif.rx_busy);
            else passed++;
            last_good = pat[i];
        end
    endtask

    task automatic test_random(input int div, input int n);
        logic [7:0] exp[$];
        logic [7:0] b;
        int base;
        os_div = div;
        idle_bits(1);
        base = valid_log.size();
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            exp.push_back(b);
            send_frame(b, 1'b1, -1);
            idle_bits($urandom_range(0, 1));
        end
        idle_bits(1);
        total++;
        if (valid_log.size() != base + n)
            $display("FAIL random_count: got %0d want %0d", valid_log.size() - base, n);
        else passed++;
        for (int i = 0; i < n; i++) begin
            total++;
            if (valid_log[base + i] !== exp[i])
                $display("FAIL random_data[%0d]: got %h want %h", i, valid_log[base + i], exp[i]);
            else passed++;
        end
        last_good = exp[n - 1];
        os_div = 27;
        idle_bits(1);
    endtask

    task automatic test_glitch;
        int base, errs;
        base = valid_log.size();
        errs = err_total;
        rxd = 1'b0;
        hold(4 * os_div);
        rxd = 1'b1;
        hold(8 * os_div);
        total++;
        if (rif.rx_busy !== 1'b0) $display("FAIL glitch_busy: got %b want 0", rif.rx_busy);
        else passed++;
        idle_bits(1);
        total++;
        if (valid_log.size() != base || err_total != errs || rif.rx_data !== last_good)
            $display("FAIL glitch_quiet: valids %0d errs %0d data %h want 0 0 %h",
                     valid_log.size() - base, err_total - errs, rif.rx_data, last_good);
        else passed++;
    endtask

    task automatic test_break;
        int base, errs;
        base = valid_log.size();
        errs = err_total;
        send_frame(8'hA5, 1'b0, -1);
        rxd = 1'b0;
        hold(20 * 16 * os_div);
        total++;
        if (err_total != errs + 1)
            $display("FAIL break_err_count: got %0d want 1", err_total - errs);
        else passed++;
        total++;
        if (rif.rx_busy !== 1'b1) $display("FAIL break_busy: got %b want 1", rif.rx_busy);
        else passed++;
        total++;
        if (valid_log.size() != base || rif.rx_data !== last_good)
            $display("FAIL break_data: valids %0d data %h want 0 %h",
                     valid_log.size() - base, rif.rx_data, last_good);
        else passed++;
        idle_bits(1);
        total++;
        if (rif.rx_busy !== 1'b0) $display("FAIL break_release: got %b want 0", rif.rx_busy);
        else passed++;
        send_frame(8'h3C, 1'b1, -1);
        idle_bits(1);
        total++;
        if (valid_log.size() != base + 1 || rif.rx_data !== 8'h3C || err_total != errs + 1)
            $display("FAIL break_recover: valids %0d data %h want 1 3c",
                     valid_log.size() - base, rif.rx_data);
        else passed++;
        last_good = 8'h3C;
    endtask

    task automatic test_back_to_back;
        int base;
        base = valid_log.size();
        send_frame(8'hA5, 1'b1, 3);
        send_frame(8'h3C, 1'b1, 3);
        idle_bits(1);
        total++;
        if (valid_log.size() != base + 2)
            $display("FAIL b2b_count: got %0d want 2", valid_log.size() - base);
        else passed++;
        total++;
        if (valid_log[base] !== 8'hA5 || valid_log[base + 1] !== 8'h3C)
            $display("FAIL b2b_data: got %h %h want a5 3c", valid_log[base], valid_log[base + 1]);
        else passed++;
        last_good = 8'h3C;
    endtask

    task automatic test_reset_midframe;
        int base;
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'($urandom), 1'b0);
        rxd = 1'b1;
        hold(6 * os_div);
        rst_n = 1'b0;
        #1;
        total++;
        if (rif.rx_data !== 8'h00 || rif.rx_valid !== 1'b0 ||
            rif.frame_err !== 1'b0 || rif.rx_busy !== 1'b0)
            $display("FAIL midreset_outputs: got %h %b %b %b want 00 0 0 0",
                     rif.rx_data, rif.rx_valid, rif.frame_err, rif.rx_busy);
        else passed++;
        hold(5);
        rst_n = 1'b1;
        idle_bits(1);
        base = valid_log.size();
        send_frame(8'hC3, 1'b1, -1);
        idle_bits(1);
        total++;
        if (valid_log.size() != base + 1 || rif.rx_data !== 8'hC3)
            $display("FAIL midreset_recover: valids %0d data %h want 1 c3",
                     valid_log.size() - base, rif.rx_data);
        else passed++;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_random(27, 3);
        test_random(1, 20);
        test_glitch;
        test_break;
        test_back_to_back;
        test_reset_midframe;
        total++;
        if (both_total != 0)
            $display("FAIL valid_err_overlap: got %0d want 0", both_total);
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
